// File: rtl/gerenciador_atributos.sv
// Virtual-pet attribute manager: a prescaler paces updates of hunger, happiness and rest levels driven by the pet state.
// Optional low-level alert comparator enabled by macro GERENCIADOR_ATRIBUTOS_ALERTA_EN.
module gerenciador_atributos #(
  parameter int TICK_DIV  = 50000000,
  parameter int GAIN      = 8,
  parameter int DECAY     = 1,
  parameter int ALERT_LIM = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] estado,
  output logic [7:0] fome,
  output logic [7:0] felicidade,
  output logic [7:0] sono,
  output logic       tick,
  output logic       alerta
);

  localparam int              CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(TICK_DIV - 1);
  localparam logic [9:0]      GAIN_W   = 10'(GAIN);
  localparam logic [9:0]      DECAY_W  = 10'(DECAY);
  localparam logic [9:0]      DECAY2_W = 10'(2 * DECAY);

  localparam logic [3:0] ST_DORMINDO   = 4'b0001;
  localparam logic [3:0] ST_COMENDO    = 4'b0010;
  localparam logic [3:0] ST_DANDO_AULA = 4'b0100;
  localparam logic [3:0] ST_MORTO      = 4'b1000;

  if (TICK_DIV < 2 || ALERT_LIM < 0 || ALERT_LIM > 256) begin : g_bad_params
    $error("gerenciador_atributos: illegal TICK_DIV or ALERT_LIM");
  end

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [7:0]    fome_nx;
  logic [7:0]    felicidade_nx;
  logic [7:0]    sono_nx;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [9:0] d);
    logic [9:0] s;
    s = {2'b00, v} + d;
    return (s > 10'd255) ? 8'd255 : s[7:0];
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] v, input logic [9:0] d);
    logic [9:0] s;
    s = {2'b00, v} - d;
    return ({2'b00, v} < d) ? 8'd0 : s[7:0];
  endfunction

  // Prescaler next count, wrapping after the tick cycle
  always_comb begin
    if (cnt == CNT_MAX) begin
      cnt_nx = '0;
    end else begin
      cnt_nx = cnt + CW'(1);
    end
  end

  // Attribute next-state; only the tick cycle's closing edge changes anything
  always_comb begin
    fome_nx       = fome;
    felicidade_nx = felicidade;
    sono_nx       = sono;
    if (tick) begin
      case (estado)
        ST_DORMINDO: begin
          fome_nx       = sat_dec(fome, DECAY_W);
          felicidade_nx = sat_dec(felicidade, DECAY_W);
          sono_nx       = sat_inc(sono, GAIN_W);
        end
        ST_COMENDO: begin
          fome_nx       = sat_inc(fome, GAIN_W);
          felicidade_nx = sat_dec(felicidade, DECAY_W);
          sono_nx       = sat_dec(sono, DECAY_W);
        end
        ST_DANDO_AULA: begin
          fome_nx       = sat_dec(fome, DECAY_W);
          felicidade_nx = sat_inc(felicidade, GAIN_W);
          sono_nx       = sat_dec(sono, DECAY2_W);
        end
        ST_MORTO: begin
          fome_nx       = fome;
          felicidade_nx = felicidade;
          sono_nx       = sono;
        end
        default: begin
          fome_nx       = sat_dec(fome, DECAY_W);
          felicidade_nx = sat_dec(felicidade, DECAY_W);
          sono_nx       = sat_dec(sono, DECAY_W);
        end
      endcase
    end else begin
      fome_nx       = fome;
      felicidade_nx = felicidade;
      sono_nx       = sono;
    end
  end

  // Prescaler, tick pulse and attribute registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      tick       <= 1'b0;
      fome       <= 8'd255;
      felicidade <= 8'd255;
      sono       <= 8'd255;
    end else begin
      cnt        <= cnt_nx;
      tick       <= (cnt_nx == CNT_MAX);
      fome       <= fome_nx;
      felicidade <= felicidade_nx;
      sono       <= sono_nx;
    end
  end

`ifdef GERENCIADOR_ATRIBUTOS_ALERTA_EN
  localparam logic [9:0] LIM_W = 10'(ALERT_LIM);

  // Alert judged on the values being loaded so it moves with the attributes
  always_ff @(posedge clk) begin
    if (rst) begin
      alerta <= 1'b0;
    end else begin
      alerta <= ({2'b00, fome_nx} < LIM_W) |
                ({2'b00, felicidade_nx} < LIM_W) |
                ({2'b00, sono_nx} < LIM_W);
    end
  end
`else
  assign alerta = 1'b0;
`endif

endmodule

// File: doc/gerenciador_atributos.md
GERENCIADOR_ATRIBUTOS -- requirements
Module: gerenciador_atributos

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per attribute-update tick (legal values ≥2).
REQ-002 Parameter GAIN, default 8, increment applied to the attribute being restored.
REQ-003 Parameter DECAY, default 1, decrement applied to the other attributes.
REQ-004 Parameter ALERT_LIM, default 32, low-level alert threshold.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 estado  input  4  pet state: IDLE=0000, DORMINDO=0001, COMENDO=0010, DANDO_AULA=0100, MORTO=1000.
REQ-008 fome  output  8  hunger-satisfaction level; 255 is full, 0 is starved.
REQ-009 felicidade  output  8  happiness level; 255 is max.
REQ-010 sono  output  8  rest level; 255 is fully rested.
REQ-011 tick  output  1  one-cycle pulse marking an update cycle.
REQ-012 alerta  output  1  high while any attribute is below ALERT_LIM (see Configuration).

Function
REQ-013 Prescaler counts 0..TICK_DIV-1 and wraps to 0; tick is high exactly on the cycle the count equals TICK_DIV-1.
REQ-014 Attributes update only at the rising edge that ends a tick-high cycle; estado is sampled on that same edge; new values are visible the following cycle.
REQ-015 IDLE: fome, felicidade and sono each decrease by DECAY.
REQ-016 COMENDO: fome increases by GAIN; felicidade and sono decrease by DECAY.
REQ-017 DORMINDO: sono increases by GAIN; fome and felicidade decrease by DECAY.
REQ-018 DANDO_AULA: felicidade increases by GAIN; fome decreases by DECAY; sono decreases by 2*DECAY.
REQ-019 MORTO: all three attributes hold their value; the prescaler and tick keep running.
REQ-020 Any estado code other than the five listed is treated as IDLE.
REQ-021 Arithmetic uses at least 10-bit intermediates; increments saturate at 255 and decrements saturate at 0; wrap-around never occurs.
REQ-022 Once an attribute reaches 0 it stays at 0 under continued decay; recovery occurs only through its restoring state.
REQ-023 Outputs are registered; there is no combinational path from estado to fome, felicidade or sono.

Reset
REQ-024 When rst is high at a rising edge: fome, felicidade and sono become 255, the prescaler becomes 0, and tick and alerta become 0.
REQ-025 rst takes priority over a coincident tick; the pending update is discarded.
REQ-026 After rst is released, the first tick occurs TICK_DIV cycles later.

Configuration
REQ-027 Macro GERENCIADOR_ATRIBUTOS_ALERTA_EN: when defined, alerta is a registered flag equal to (fome<ALERT_LIM)|(felicidade<ALERT_LIM)|(sono<ALERT_LIM). It is computed from the next-state values, so it changes in the same cycle as the attributes.
REQ-028 When the macro is undefined, alerta is tied to 0, the port remains present, and no comparator logic is synthesized.

Verification (TICK_DIV=4, GAIN=8, DECAY=1, ALERT_LIM=32)
REQ-029 Reset, then estado=IDLE for 12 cycles -> tick pulses on cycles 3, 7 and 11; after the third tick, all attributes are 252.
REQ-030 IDLE for 10 ticks (all 245), then COMENDO for 2 ticks -> fome 253 then 255 (saturated); felicidade and sono 243.
REQ-031 IDLE for 260 ticks -> all attributes reach 0 at tick 255 and remain 0 with no wrap to 255; then DORMINDO for 1 tick -> sono 8, fome 0, felicidade 0.
REQ-032 IDLE for 5 ticks (250), then MORTO for 10 ticks -> all attributes stay 250; tick keeps pulsing every 4 cycles.
REQ-033 rst asserted on a tick-high cycle after 3 updates -> next cycle all attributes are 255 and tick is 0; first tick occurs 4 cycles after release.
REQ-034 Macro defined, DANDO_AULA from reset -> sono decrements by 2 per tick and reaches 31 after tick 112; alerta rises in that same cycle. Macro undefined, same stimulus -> alerta stays 0.
